// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer: FSM state encoding,
// default geometry and the slot-index width helper.
package tdm_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } tdm_state_e;

  localparam int unsigned TDM_CHANNELS = 4;
  localparam int unsigned TDM_WIDTH    = 4;

  function automatic int unsigned slot_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-CHANNELS slot counter with advance enable, synchronous load-to-1 and a
// wrap flag that is high while the counter sits on the last slot.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned SW       = slot_w(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_load1,
  output logic [SW-1:0] o_cnt,
  output logic          o_wrap
);

  logic [SW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == SW'(CHANNELS - 1));
  assign o_wrap = w_wrap;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= SW'(1);
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: serial slot beats into a double-buffered parallel frame.
// Optional per-beat even parity checking enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned WIDTH    = TDM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        E,
  input  logic                        V,
  input  logic                        F,
  input  logic [WIDTH-1:0]            D,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                        P,
  output logic                        parity_err,
`endif
  output logic [CHANNELS*WIDTH-1:0]   Y,
  output logic [slot_w(CHANNELS)-1:0] S,
  output logic                        frame_valid,
  output logic                        locked,
  output logic                        sync_err
);

  localparam int unsigned SW = slot_w(CHANNELS);

  tdm_state_e                r_state;
  logic [WIDTH-1:0]          r_shadow [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] r_y;
  logic                      r_fv;
  logic                      r_serr;
  logic                      r_locked;

  logic                      w_beat;
  logic                      w_load;
  logic                      w_inc;
  logic                      w_wrap;
  logic                      w_commit;
  logic                      w_commit_ok;
  logic                      w_misalign;
  logic [SW-1:0]             w_s;
  logic [CHANNELS*WIDTH-1:0] w_frame;

  // A sync beat always lands in slot 0 and leaves S=1, whether it starts the
  // first frame, a regular frame, or restarts a misaligned one.
  assign w_beat     = E & V;
  assign w_load     = w_beat & F;
  assign w_inc      = w_beat & ~F & (r_state == LOCKED);
  assign w_commit   = w_inc & w_wrap;
  assign w_misalign = w_load & (r_state == LOCKED) & (w_s != '0);

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_inc),
    .i_load1 (w_load),
    .o_cnt   (w_s),
    .o_wrap  (w_wrap)
  );

  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < CHANNELS - 1; k++) begin
      w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
    end
    w_frame[(CHANNELS-1)*WIDTH +: WIDTH] = D;
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic r_bad;
  logic r_perr;
  logic w_perr;

  assign w_perr      = (P != ^D) & (w_load | w_inc);
  assign w_commit_ok = w_commit & ~(r_bad | w_perr);
  assign parity_err  = r_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_perr) r_perr <= 1'b1;
      if (w_load) begin
        r_bad <= w_perr;
      end else if (w_inc) begin
        r_bad <= w_commit ? 1'b0 : (r_bad | w_perr);
      end
    end
  end
`else
  assign w_commit_ok = w_commit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= UNLOCKED;
      r_y      <= '0;
      r_fv     <= 1'b0;
      r_serr   <= 1'b0;
      r_locked <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_fv   <= 1'b0;
      r_serr <= 1'b0;
      if (w_load) begin
        r_shadow[0] <= D;
        r_state     <= LOCKED;
        r_locked    <= 1'b1;
        r_serr      <= w_misalign;
      end else if (w_inc) begin
        r_shadow[w_s] <= D;
        if (w_commit_ok) begin
          r_y  <= w_frame;
          r_fv <= 1'b1;
        end
      end
    end
  end

  assign Y           = r_y;
  assign S           = w_s;
  assign frame_valid = r_fv;
  assign locked      = r_locked;
  assign sync_err    = r_serr;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames plus randomized beats against a
// queue-based frame model; parity port driven correct under TDM_DEMUX_PARITY_EN.
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            E, V, F;
  logic [W-1:0]    D;
  logic [CH*W-1:0] Y;
  logic [1:0]      S;
  logic            frame_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic            P;
  logic            parity_err;
  assign P = ^D;
`endif

  int total = 0;
  int bad   = 0;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .E           (E),
    .V           (V),
    .F           (F),
    .D           (D),
`ifdef TDM_DEMUX_PARITY_EN
    .P           (P),
    .parity_err  (parity_err),
`endif
    .Y           (Y),
    .S           (S),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Model: the in-progress frame is a queue of accepted slot values.
  logic [W-1:0]    q[$];
  bit              m_locked;
  logic [CH*W-1:0] m_y;
  bit              m_fv, m_se;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_locked = 0;
      m_y      = '0;
      m_fv     = 0;
      m_se     = 0;
    end else begin
      m_fv = 0;
      m_se = 0;
      if (E && V) begin
        if (F) begin
          if (m_locked && q.size() != 0) m_se = 1;
          q.delete();
          q.push_back(D);
          m_locked = 1;
        end else if (m_locked) begin
          q.push_back(D);
          if (q.size() == CH) begin
            m_y = '0;
            for (int i = 0; i < CH; i++) m_y = m_y | ({{(CH*W-W){1'b0}}, q[i]} << (W*i));
            m_fv = 1;
            q.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("Y", 32'(Y), 32'(m_y));
    chk("S", 32'(S), 32'(q.size()));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_se));
`ifdef TDM_DEMUX_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'd0);
`endif
  end

  task automatic bt(input logic f, input logic [W-1:0] d,
                    input logic e = 1'b1, input logic v = 1'b1);
    E = e; V = v; F = f; D = d;
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_Y", 32'(Y), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; E = 1'b0; V = 1'b0; F = 1'b0; D = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unlocked beats without sync are ignored
    bt(0, 4'h5); bt(0, 4'h6);
    chk("unlocked_locked", 32'(locked), 32'd0);
    chk("unlocked_S", 32'(S), 32'd0);

    // First frame
    bt(1, 4'h1); bt(0, 4'h2); bt(0, 4'h3); bt(0, 4'h4);
    chk("frame1_Y", 32'(Y), 32'h4321);
    chk("frame1_fv", 32'(frame_valid), 32'd1);
    chk("frame1_locked", 32'(locked), 32'd1);
    bt(0, 4'h0, 1'b1, 1'b0);
    chk("frame1_fv_drop", 32'(frame_valid), 32'd0);

    // Back-to-back frames, second without sync
    bt(1, 4'hA); bt(0, 4'hB); bt(0, 4'hC); bt(0, 4'hD);
    chk("b2b_Y1", 32'(Y), 32'hDCBA);
    bt(0, 4'h5); bt(0, 4'h6); bt(0, 4'h7);
    chk("b2b_hold", 32'(Y), 32'hDCBA);
    bt(0, 4'h8);
    chk("b2b_Y2", 32'(Y), 32'h8765);
    chk("b2b_fv2", 32'(frame_valid), 32'd1);

    // Misaligned sync discards the partial frame
    bt(1, 4'h1); bt(0, 4'h2); bt(1, 4'h9);
    chk("misalign_serr", 32'(sync_err), 32'd1);
    chk("misalign_S", 32'(S), 32'd1);
    chk("misalign_Y_hold", 32'(Y), 32'h8765);
    bt(0, 4'hA);
    chk("misalign_serr_drop", 32'(sync_err), 32'd0);
    bt(0, 4'hB); bt(0, 4'hC);
    chk("misalign_Y", 32'(Y), 32'hCBA9);

    // Enable gating freezes a frame mid-way
    bt(1, 4'h3); bt(0, 4'h5);
    for (int i = 0; i < 5; i++) begin
      bt(i[0], (i[0] ? 4'hF : 4'h0), 1'b0, 1'b1);
      chk("gate_S", 32'(S), 32'd2);
    end
    chk("gate_Y_hold", 32'(Y), 32'hCBA9);
    bt(0, 4'h7); bt(0, 4'hE);
    chk("gate_Y", 32'(Y), 32'hE753);

    // Reset mid-frame
    bt(1, 4'h2); bt(0, 4'h4);
    async_reset();
    chk("post_rst_locked", 32'(locked), 32'd0);

    // Randomized stream with occasional mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      bt(($urandom_range(0, 7) == 0), 4'($urandom),
         ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
